// File: rtl/div_n_serial.sv
// Serial divisibility checker.
// Consumes a binary number one bit per accepted cycle (MSB-first or LSB-first)
// and keeps the running remainder modulo DIVISOR, flagging divisibility.
//
// Input qualification: there is no backpressure. A bit is taken on every
// rising edge where in_valid=1 and reset=0; when in_valid=0 all state holds
// (apart from clear and the upd pulse returning low).
module div_n_serial #(
  parameter int DIVISOR   = 3,
  parameter int LSB_FIRST = 0,
  parameter int CNT_W     = 16,
  localparam int RW = ($clog2(DIVISOR) < 1) ? 1 : $clog2(DIVISOR)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             bit_in,
  output logic [RW-1:0]    rem,
  output logic             out,
  output logic [CNT_W-1:0] nbits,
  output logic             upd
);

  // Reject divisors the datapath was not sized for.
  if (DIVISOR < 2 || DIVISOR > 65536) begin : g_bad_divisor
    $error("div_n_serial: DIVISOR must be in 2..65536");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("div_n_serial: CNT_W must be at least 1");
  end

  // DIVISOR in RW+1 bits; a power-of-two divisor needs the extra bit.
  localparam logic [RW:0] DIV_X = (RW + 1)'(DIVISOR);

  // pw holds 2^k mod DIVISOR for the next LSB-first bit position k.
  logic [RW-1:0]    pw;
  logic [RW-1:0]    rem_base;
  logic [RW-1:0]    pw_base;
  logic [CNT_W-1:0] cnt_base;
  logic [RW:0]      sum;
  logic [RW:0]      dbl;
  logic [RW-1:0]    rem_next;
  logic [RW-1:0]    pw_next;
  logic [CNT_W-1:0] cnt_next;

  // Next-state datapath. A clear in the same cycle as an accepted bit starts
  // from an empty frame, so the bases fall back to the post-clear values.
  // Both operands stay below 2*DIVISOR, so one conditional subtract reduces.
  always_comb begin
    rem_base = clear ? '0 : rem;
    pw_base  = clear ? RW'(1) : pw;
    cnt_base = clear ? '0 : nbits;
    sum      = '0;
    if (LSB_FIRST != 0) begin
      sum = {1'b0, rem_base} + (bit_in ? {1'b0, pw_base} : '0);
    end else begin
      sum = {rem_base, bit_in};
    end
    rem_next = (sum >= DIV_X) ? RW'(sum - DIV_X) : sum[RW-1:0];
    dbl      = {pw_base, 1'b0};
    pw_next  = (dbl >= DIV_X) ? RW'(dbl - DIV_X) : dbl[RW-1:0];
    cnt_next = (&cnt_base) ? cnt_base : cnt_base + 1'b1;
  end

  // State registers: reset beats everything, an accepted bit beats a bare clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem   <= '0;
      pw    <= RW'(1);
      nbits <= '0;
      out   <= 1'b1;
      upd   <= 1'b0;
    end else if (in_valid) begin
      rem   <= rem_next;
      pw    <= pw_next;
      nbits <= cnt_next;
      out   <= (rem_next == '0);
      upd   <= 1'b1;
    end else if (clear) begin
      rem   <= '0;
      pw    <= RW'(1);
      nbits <= '0;
      out   <= 1'b1;
      upd   <= 1'b0;
    end else begin
      upd   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_div_n_serial.sv
// Bench for div_n_serial: several instances with different DIVISOR / bit order
// share one input stream; a frame-level reference model predicts every output.
module tb_div_n_serial;

  localparam int NI = 11;
  localparam int DV [NI] = '{3, 5, 3, 7, 2, 8, 13, 13, 8, 5, 2};
  localparam int LS [NI] = '{0, 0, 1, 0, 1, 0, 1,  0,  1, 1, 0};
  localparam int CW [NI] = '{16, 16, 16, 3, 16, 16, 16, 16, 16, 16, 16};

  // clock / reset block
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic bit_in = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0][15:0] rem_o;
  logic [NI-1:0][15:0] nb_o;
  logic [NI-1:0]       out_v;
  logic [NI-1:0]       upd_v;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int RWG = ($clog2(DV[g]) < 1) ? 1 : $clog2(DV[g]);
    logic [RWG-1:0]   r;
    logic [CW[g]-1:0] n;
    div_n_serial #(.DIVISOR(DV[g]), .LSB_FIRST(LS[g]), .CNT_W(CW[g])) dut (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
      .bit_in(bit_in), .rem(r), .out(out_v[g]), .nbits(n), .upd(upd_v[g])
    );
    assign rem_o[g] = 16'(r);
    assign nb_o[g]  = 16'(n);
  end

  // scoreboard: bits of the current frame, in arrival order
  logic frame_q[$];
  logic upd_exp = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   upd_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Value of the frame modulo d, from its numeric weight, most significant first.
  function automatic int model_mod(int g);
    int d = DV[g];
    int v = 0;
    int n = frame_q.size();
    for (int i = 0; i < n; i++) begin
      int k = (LS[g] != 0) ? (n - 1 - i) : i;
      v = (v * 2 + int'(frame_q[k])) % d;
    end
    return v;
  endfunction

  function automatic int model_nbits(int g);
    int cap = (1 << CW[g]) - 1;
    return (frame_q.size() > cap) ? cap : frame_q.size();
  endfunction

  task automatic check_all();
    for (int g = 0; g < NI; g++) begin
      int m = model_mod(g);
      check($sformatf("u%0d_rem", g), 32'(rem_o[g]), 32'(m));
      check($sformatf("u%0d_out", g), 32'(out_v[g]), 32'(m == 0));
      check($sformatf("u%0d_nbits", g), 32'(nb_o[g]), 32'(model_nbits(g)));
      check($sformatf("u%0d_upd", g), 32'(upd_v[g]), 32'(upd_exp));
    end
  endtask

  // driver: apply one cycle of inputs, advance the model, check after the edge
  task automatic step(input logic v, input logic b, input logic c, input logic r);
    in_valid = v;
    bit_in   = b;
    clear    = c;
    reset    = r;
    @(posedge clk);
    if (r) begin
      frame_q.delete();
      upd_exp = 1'b0;
    end else if (v) begin
      if (c) frame_q.delete();
      frame_q.push_back(b);
      upd_exp = 1'b1;
    end else begin
      if (c) frame_q.delete();
      upd_exp = 1'b0;
    end
    #1;
    check_all();
    upd_cnt += int'(upd_v[1]);
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, bits[i], 1'b0, 1'b0);
      for (int j = 0; j < gap && i > 0; j++) step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    // reset state
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_out", 32'(out_v[0]), 32'd1);
    check("rst_rem", 32'(rem_o[0]), 32'd0);

    // /3 MSB: 1,1 -> 3
    send_bits(16'b11, 2, 0);
    check("d3_11_rem", 32'(rem_o[0]), 32'd0);
    check("d3_11_out", 32'(out_v[0]), 32'd1);
    check("d3_11_nbits", 32'(nb_o[0]), 32'd2);

    // /3 MSB: clear, then 0,1,1,0 -> 6
    step(1'b0, 1'b0, 1'b1, 1'b0);
    send_bits(16'b01, 2, 0);
    check("d3_01_out", 32'(out_v[0]), 32'd0);
    check("d3_01_rem", 32'(rem_o[0]), 32'd1);
    send_bits(16'b1, 1, 0);
    check("d3_011_out", 32'(out_v[0]), 32'd1);
    send_bits(16'b0, 1, 0);
    check("d3_0110_out", 32'(out_v[0]), 32'd1);
    check("d3_0110_rem", 32'(rem_o[0]), 32'd0);
    check("d3_0110_nbits", 32'(nb_o[0]), 32'd4);

    // /5 MSB: 1,1,1 -> 7, then the same with 3-cycle gaps
    step(1'b0, 1'b0, 1'b1, 1'b0);
    send_bits(16'b111, 3, 0);
    check("d5_111_rem", 32'(rem_o[1]), 32'd2);
    check("d5_111_out", 32'(out_v[1]), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    upd_cnt = 0;
    send_bits(16'b111, 3, 3);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("d5_gap_rem", 32'(rem_o[1]), 32'd2);
    check("d5_gap_out", 32'(out_v[1]), 32'd0);
    check("d5_gap_upd_count", 32'(upd_cnt), 32'd3);

    // /3 LSB: 1,0,1 -> 5; then 1 -> 13; then clear with a bit of 1
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("lsb3_5_rem", 32'(rem_o[2]), 32'd2);
    check("lsb3_5_out", 32'(out_v[2]), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("lsb3_13_rem", 32'(rem_o[2]), 32'd1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("lsb3_clr_rem", 32'(rem_o[2]), 32'd1);
    check("lsb3_clr_nbits", 32'(nb_o[2]), 32'd1);

    // /7 MSB, 3-bit counter: nine 1s -> 511, counter saturates at 7
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("d7_511_out", 32'(out_v[3]), 32'd1);
    check("d7_511_rem", 32'(rem_o[3]), 32'd0);
    check("d7_511_nbits", 32'(nb_o[3]), 32'd7);

    // reset mid-stream drops the partial number and the reset-cycle bit
    step(1'b0, 1'b0, 1'b1, 1'b0);
    send_bits(16'b10, 2, 0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    send_bits(16'b11, 2, 0);
    check("rstmid_rem", 32'(rem_o[0]), 32'd0);
    check("rstmid_out", 32'(out_v[0]), 32'd1);
    check("rstmid_nbits", 32'(nb_o[0]), 32'd2);

    // randomized streams across all divisors and both bit orders
    for (int i = 0; i < 800; i++) begin
      logic r, c, v, b;
      r = ($urandom_range(0, 99) == 0);
      c = ($urandom_range(0, 99) < 4);
      v = ($urandom_range(0, 9) < 7);
      b = 1'($urandom_range(0, 1));
      step(v, b, c, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_n_serial.md
# div_n_serial

Serial divisibility checker: consumes a binary number one bit per accepted cycle and keeps its running remainder modulo a parameterised divisor, flagging when the number received so far is divisible. It generalises the fixed divide-by-3 detector to any divisor ≥ 2. It supports both MSB-first and LSB-first bit order, adds input qualification and frame restart, and reports the remainder and bit count. It sits at the end of serial input paths, where it checks framed numeric streams without deserialising them.

## Interface

Parameters:
- DIVISOR, default 3: modulus; legal range 2..2^16; checked at elaboration.
- LSB_FIRST, default 0: 0 means bits arrive MSB first; 1 means LSB first.
- CNT_W, default 16: width of the bit counter.
- Derived localparam RW = $clog2(DIVISOR); remainder width, minimum 1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous frame restart; lower priority than reset.
- in_valid  input  1  qualifies bit; when low, all state holds.
- bit  input  1  next bit of the number.
- rem  output  RW  remainder of the number received so far, modulo DIVISOR; registered.
- out  output  1  registered; 1 when rem == 0.
- nbits  output  CNT_W  bits accepted since reset or clear; saturates at all-ones.
- upd  output  1  one-cycle pulse, asserted the cycle after each accepted bit.

## Operation

- Internal state: rem (RW bits), pw (RW bits, LSB_FIRST only, holds 2^k mod DIVISOR), nbits, out, upd.
- Reset (reset=1 at an edge):
  - rem=0, out=1 (the empty number is 0, which is divisible).
  - nbits=0, upd=0.
  - pw = 1 mod DIVISOR, which is 1 for all legal DIVISOR.
  - Reset overrides clear and in_valid.
- Accept condition: in_valid=1 and reset=0.
- MSB-first update on accept: t = 2·rem + bit; rem ← (t ≥ DIVISOR) ? t − DIVISOR : t.
- LSB-first update on accept:
  - t = rem + (bit ? pw : 0); rem ← t mod DIVISOR.
  - pw ← (2·pw) mod DIVISOR.
- Arithmetic: each operand is < 2·DIVISOR, so a single conditional subtract suffices. Intermediates are RW+1 bits wide. No dividers and no `%` operator on variables.
- out ← (rem_next == 0); it is registered in the same edge as rem and is always consistent with rem.
- nbits ← nbits + 1 on accept; it holds at 2^CNT_W − 1 once reached. rem and pw keep updating after saturation.
- upd ← accept; upd is 0 on any cycle without an accept.
- clear=1 without in_valid:
  - rem=0, out=1, pw=1, nbits=0, upd=0.
- clear=1 with in_valid=1 in the same cycle:
  - The frame restarts and the bit is taken as the first bit of the new number.
  - Resulting state is rem = bit mod DIVISOR, nbits=1, upd=1, out=(rem==0).
  - LSB_FIRST: pw ← 2 mod DIVISOR.
- in_valid=0 gaps of any length are transparent: the result equals that of a gapless stream.
- DIVISOR a power of two: the same datapath applies, with no special-casing.

## Timing

- Latency is 1 cycle. A bit accepted at edge k is reflected in rem/out/nbits/upd immediately after edge k.
- There is no backpressure; the block accepts one bit every cycle.
- All outputs come directly from flops; there are no combinational paths from inputs to outputs.
- Reset mid-stream discards the partial number at that edge. A bit presented in the reset cycle is dropped.
- Throughput is one bit per cycle at any DIVISOR. The critical path is one add plus one compare/subtract of RW+1 bits.

## Test plan

- DIVISOR=3, MSB: after reset, accept 1,1 (value 3) -> rem=0, out=1, nbits=2. The initial state after reset is out=1, rem=0.
- DIVISOR=3, MSB: clear, then accept 0,1,1,0 (value 6) -> out=1 after the 4th accept, rem=0, nbits=4. After the 3rd accept (value 3) out=1; after the 2nd accept (value 1) out=0, rem=1.
- DIVISOR=5, MSB: accept 1,1,1 (value 7) -> rem=2, out=0. Add in_valid=0 gaps of 3 cycles between bits -> identical result, and upd pulses exactly 3 times.
- DIVISOR=3, LSB_FIRST=1: accept 1,0,1 (value 5) -> rem=2, out=0. Then accept 1 (value 13) -> rem=1. Then clear with in_valid=1, bit=1 in the same cycle -> rem=1, nbits=1.
- DIVISOR=7, MSB, CNT_W=3: accept 9 bits of 1 (value 511 = 7·73) -> out=1, rem=0, nbits=7 (saturated).
- DIVISOR=3, MSB: accept 1,0, then assert reset for 1 cycle with in_valid=1, bit=1, then accept 1,1 -> rem=0, out=1, nbits=2, and the reset-cycle bit is ignored. Also sweep DIVISOR in {2,3,5,8,13} with random MSB/LSB streams against a reference model of the value mod DIVISOR.
